timeout_timer_ctrl: RTL

Programmable millisecond timeout controller for PlaySeq. It derives a 1 ms tick enable from the 50 MHz system clock, counts down a loaded limit, and flags expiry. Game FSMs use it for per-move and per-round timeouts. Start, pause, resume, cancel and restart are handled by an internal 4-state FSM. All logic runs on the single system clock; the tick is an enable, never a derived clock.

---
 rtl/playseq_pkg.sv | 14 +
 rtl/tick_prescaler.sv | 33 +++
 rtl/timeout_timer_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/playseq_pkg.sv
// Shared PlaySeq definitions: timeout controller state encodings and default tick rate.
package playseq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  // 1 ms at 50 MHz
  localparam int DEFAULT_CLK_PER_TICK = 50000;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..CLK_PER_TICK-1 counter that yields a one-cycle wrap enable.
module tick_prescaler
  import playseq_pkg::*;
#(
  parameter int CLK_PER_TICK = DEFAULT_CLK_PER_TICK
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic wrap
);

  localparam int PW = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
  localparam logic [PW-1:0] TERM = PW'(CLK_PER_TICK - 1);
  localparam logic [PW-1:0] ONE  = PW'(1);

  logic [PW-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == TERM) ? '0 : cnt + ONE;
    end
  end

  // clr wins so a restart or cancel never leaks a wrap in the same cycle
  assign wrap = en && !clr && (cnt == TERM);

endmodule

// File: rtl/timeout_timer_ctrl.sv
// Programmable tick-based timeout controller: start/pause/resume/cancel FSM and remaining counter.
module timeout_timer_ctrl
  import playseq_pkg::*;
#(
  parameter int CLK_PER_TICK = DEFAULT_CLK_PER_TICK,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             cancel,
  input  logic [CNT_W-1:0] limit,
  output logic             tick,
  output logic [CNT_W-1:0] remaining,
  output logic             active,
  output logic             timeout,
  output logic             expired,
  output logic [1:0]       state_db
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] remaining_nx;
  logic             tick_nx;
  logic             timeout_nx;
  logic             counting;
  logic             pre_clr;
  logic             pre_en;
  logic             wrap;

  // A paused timer resumes counting on the very edge pause is seen low,
  // so PAUSE counts too whenever pause has dropped.
  assign counting = ((state == ST_RUN) || (state == ST_PAUSE)) && !pause;
  assign pre_clr  = start || cancel;
  assign pre_en   = counting && !pre_clr;

  tick_prescaler #(
    .CLK_PER_TICK(CLK_PER_TICK)
  ) u_prescaler (
    .clock(clock),
    .reset(reset),
    .en   (pre_en),
    .clr  (pre_clr),
    .wrap (wrap)
  );

  always_comb begin
    state_nx     = state;
    remaining_nx = remaining;
    tick_nx      = 1'b0;
    timeout_nx   = 1'b0;
    if (cancel) begin
      state_nx     = ST_IDLE;
      remaining_nx = '0;
    end else if (start) begin
      remaining_nx = limit;
      if (limit != '0) begin
        state_nx = ST_RUN;
      end else begin
        state_nx   = ST_DONE;
        timeout_nx = 1'b1;
      end
    end else begin
      case (state)
        ST_RUN, ST_PAUSE: begin
          if (pause) begin
            state_nx = ST_PAUSE;
          end else begin
            state_nx = ST_RUN;
            if (wrap) begin
              tick_nx = 1'b1;
              if (remaining != '0) begin
                remaining_nx = remaining - ONE;
              end
              if (remaining == ONE) begin
                timeout_nx = 1'b1;
                state_nx   = ST_DONE;
              end
            end
          end
        end
        default: begin
          state_nx = state;
        end
      endcase
    end
  end

  // Status flags come from the next state so they flop alongside the state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      remaining <= '0;
      tick      <= 1'b0;
      timeout   <= 1'b0;
      active    <= 1'b0;
      expired   <= 1'b0;
    end else begin
      state     <= state_nx;
      remaining <= remaining_nx;
      tick      <= tick_nx;
      timeout   <= timeout_nx;
      active    <= (state_nx == ST_RUN) || (state_nx == ST_PAUSE);
      expired   <= (state_nx == ST_DONE);
    end
  end

  assign state_db = state;

endmodule
